alu_result_stage: RTL and testbench

- Registered output stage directly downstream of the combinational 4-bit ALU datapath (gate-level adder/logic slices and zero-detect).
- Captures each ALU result and carry-out, derives the Z/N/C/V flags, and buffers result+flags in a small FIFO with a valid/ready handshake toward the consumer (writeback / display).
- Also keeps a sticky overflow flag for software-visible error reporting.

---
 rtl/alu_result_stage.sv | 100 ++++++++++
 tb/tb_alu_result_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Registered output stage for the 4-bit ALU: derives Z/N/C/V at the input,
// buffers {result, flags} in a small FIFO and keeps a sticky overflow bit.
module alu_result_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] r,
    input  logic             cout,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [3:0]       flags,
    output logic [LVL_W-1:0] level,
    output logic             sticky_v,
    input  logic             clr_sticky
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = WIDTH + 4;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             sticky_q, sticky_d;

    logic             z_in, n_in, v_in;
    logic [3:0]       flags_in;
    logic             push, pop;
    logic [ENT_W-1:0] head;

    // Subtract overflow compares A against the un-inverted B, hence the flipped sign test.
    always_comb begin
        z_in     = ~|r;
        n_in     = r[WIDTH-1];
        v_in     = sub ? ((a_msb != b_msb) & (r[WIDTH-1] != a_msb))
                       : ((a_msb == b_msb) & (r[WIDTH-1] != a_msb));
        flags_in = {z_in, n_in, cout, v_in};
    end

    always_comb begin
        in_ready  = (level_q != LVL_W'(DEPTH));
        out_valid = (level_q != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        sticky_d = sticky_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        // A new overflow outranks a clear arriving in the same cycle.
        if (push && v_in)   sticky_d = 1'b1;
        else if (clr_sticky) sticky_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sticky_q <= sticky_d;
        end
    end

    // Storage is left uncleared; pointers and level alone define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {r, flags_in};
    end

    always_comb begin
        head     = mem_q[rd_ptr_q];
        q        = out_valid ? head[ENT_W-1:4] : '0;
        flags    = out_valid ? head[3:0] : 4'b0000;
        level    = level_q;
        sticky_v = sticky_q;
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed-vector bench for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] r;
    logic       cout;
    logic       a_msb;
    logic       b_msb;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] q;
    logic [3:0] flags;
    logic [2:0] level;
    logic       sticky_v;
    logic       clr_sticky;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];

    alu_result_stage #(.WIDTH(4), .DEPTH(4), .LVL_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .r(r), .cout(cout), .a_msb(a_msb), .b_msb(b_msb), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .q(q), .flags(flags),
        .level(level), .sticky_v(sticky_v), .clr_sticky(clr_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] rv, input logic c, input logic a,
                         input logic b, input logic s);
        r = rv; cout = c; a_msb = a; b_msb = b; sub = s; in_valid = 1'b1;
    endtask

    task automatic push1(input logic [3:0] rv, input logic c, input logic a,
                         input logic b, input logic s);
        drive(rv, c, a, b, s);
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic clr1();
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; r = '0; cout = 1'b0; a_msb = 1'b0;
        b_msb = 1'b0; sub = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        step(); step();
        chk("rst_level", level, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_q", q, 0);
        chk("rst_flags", flags, 0);
        chk("rst_sticky", sticky_v, 0);
        rst_n = 1'b1;
        step();
        chk("rst_inready", in_ready, 1);

        // zero / negative flags
        push1(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("z_ovalid", out_valid, 1);
        chk("z_q", q, 4'h0);
        chk("z_flags", flags, 4'b1010);
        chk("z_level", level, 1);
        pop1();
        chk("z_pop_level", level, 0);
        chk("z_pop_ovalid", out_valid, 0);
        push1(4'b1001, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("n_q", q, 4'h9);
        chk("n_flags", flags, 4'b0100);
        chk("n_sticky", sticky_v, 0);
        pop1();

        // overflow and sticky
        push1(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("vadd_flags", flags, 4'b0101);
        chk("vadd_sticky", sticky_v, 1);
        pop1();
        clr1();
        chk("clr_sticky", sticky_v, 0);
        push1(4'b0111, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("vsub_flags", flags, 4'b0011);
        chk("vsub_sticky", sticky_v, 1);
        pop1();
        clr1();
        push1(4'b1111, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("nvsub_flags", flags, 4'b0100);
        chk("nvsub_sticky", sticky_v, 0);
        pop1();
        clr_sticky = 1'b1;
        push1(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
        clr_sticky = 1'b0;
        chk("setclr_sticky", sticky_v, 1);
        pop1();
        clr1();
        chk("clr2_sticky", sticky_v, 0);

        // fill to full, hold a fifth value, then drain
        for (int i = 1; i <= 4; i++) push1(4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_level", level, 4);
        chk("full_inready", in_ready, 0);
        drive(4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); step();
        chk("full_hold_level", level, 4);
        chk("full_hold_q", q, 4'd1);
        out_ready = 1'b1;
        step();
        chk("drain1_q", q, 4'd2);
        chk("drain1_level", level, 3);
        chk("drain1_inready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("drain2_q", q, 4'd3);
        chk("drain2_level", level, 3);
        step();
        chk("drain3_q", q, 4'd4);
        step();
        chk("drain4_q", q, 4'd5);
        chk("drain4_level", level, 1);
        step();
        chk("drain5_ovalid", out_valid, 0);
        chk("drain5_level", level, 0);
        out_ready = 1'b0;

        // streaming at level 2 across pointer wrap
        push1(4'd6, 1'b0, 1'b0, 1'b0, 1'b0); exp_q.push_back(4'd6);
        push1(4'd7, 1'b0, 1'b0, 1'b0, 1'b0); exp_q.push_back(4'd7);
        chk("strm_pre_level", level, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [3:0] v;
            v = 4'(8 + i);
            drive(v, 1'b0, v[3], v[3], 1'b0);
            step();
            void'(exp_q.pop_front());
            exp_q.push_back(v);
            chk("strm_level", level, 2);
            chk("strm_q", q, exp_q[0]);
        end
        in_valid = 1'b0;
        step();
        void'(exp_q.pop_front());
        chk("strm_tail_q", q, exp_q[0]);
        step();
        chk("strm_empty_level", level, 0);

        // empty: out_ready high, nothing pushed
        for (int i = 0; i < 4; i++) begin
            step();
            chk("empty_ovalid", out_valid, 0);
            chk("empty_q", q, 0);
            chk("empty_flags", flags, 0);
            chk("empty_level", level, 0);
        end
        out_ready = 1'b0;

        // reset mid-operation
        push1(4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        push1(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
        push1(4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("prerst_level", level, 3);
        chk("prerst_sticky", sticky_v, 1);
        rst_n = 1'b0;
        drive(4'hA, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        rst_n = 1'b1;
        in_valid = 1'b0;
        chk("midrst_level", level, 0);
        chk("midrst_ovalid", out_valid, 0);
        chk("midrst_sticky", sticky_v, 0);
        chk("midrst_inready", in_ready, 1);
        chk("midrst_q", q, 0);
        push1(4'hC, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("postrst_level", level, 1);
        chk("postrst_q", q, 4'hC);
        chk("postrst_flags", flags, 4'b0110);
        pop1();
        chk("postrst_pop_level", level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
